// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state encoding for the digit-serial adder
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fa_mux_cell.sv
// rtl/fa_mux_cell.sv - 1-bit full adder built from two 4:1 muxes selected by {b,c}
module fa_mux_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   logic [1:0] sel;
   assign sel = {b, c};

   always_comb begin
      s  = a;
      co = 1'b0;
      case (sel)
         2'b00: begin s = a;  co = 1'b0; end
         2'b01: begin s = ~a; co = a;    end
         2'b10: begin s = ~a; co = a;    end
         2'b11: begin s = a;  co = 1'b1; end
         default: begin s = a; co = 1'b0; end
      endcase
   end

endmodule

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - digit-serial add/subtract, DIGIT bits per cycle, LSB digit first
module digit_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NDIG = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   generate
      if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_param
         $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_shift;
   logic [CW-1:0]    cnt;
   logic             carry, cout_reg, ovf_reg;
   logic [DIGIT:0]   chain;
   logic [DIGIT-1:0] dig_sum;
   logic             accept, last;

   // Operands shift right each RUN cycle, so the current digit is always in the low bits.
   assign chain[0] = carry;

   generate
      for (genvar i = 0; i < DIGIT; i++) begin : g_cell
         fa_mux_cell u_cell (
            .a  (a_reg[i]),
            .b  (b_reg[i]),
            .c  (chain[i]),
            .s  (dig_sum[i]),
            .co (chain[i+1])
         );
      end
      if (DIGIT == WIDTH) begin : g_sum_full
         assign sum_shift = dig_sum;
      end else begin : g_sum_shift
         assign sum_shift = {dig_sum, sum_reg[WIDTH-1:DIGIT]};
      end
   endgenerate

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (cnt == LAST);
   assign sum       = sum_reg;
   assign cout      = cout_reg;
   assign ovf       = ovf_reg;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_reg    <= '0;
         b_reg    <= '0;
         sum_reg  <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         cout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            // Subtraction is A + ~B + 1; the forced carry-in supplies the +1.
            a_reg   <= a;
            b_reg   <= sub ? ~b : b;
            carry   <= sub ? 1'b1 : cin;
            sum_reg <= '0;
            cnt     <= '0;
         end else if (state == RUN) begin
            a_reg   <= a_reg >> DIGIT;
            b_reg   <= b_reg >> DIGIT;
            sum_reg <= sum_shift;
            carry   <= chain[DIGIT];
            cnt     <= cnt + 1'b1;
            if (last) begin
               cout_reg <= chain[DIGIT];
               ovf_reg  <= chain[DIGIT] ^ chain[DIGIT-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - self-checking bench for three digit_serial_adder configurations
module tb_digit_serial_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid_r [3];
   logic       out_ready_r[3];
   logic       cin_r      [3];
   logic       sub_r      [3];
   logic [7:0] a_r        [3];
   logic [7:0] b_r        [3];
   logic       in_ready_w [3];
   logic       out_valid_w[3];
   logic       cout_w     [3];
   logic       ovf_w      [3];
   logic [7:0] sum0, sum1;
   logic [3:0] sum2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid_r[0]), .in_ready(in_ready_w[0]),
      .a(a_r[0]), .b(b_r[0]), .cin(cin_r[0]), .sub(sub_r[0]),
      .out_valid(out_valid_w[0]), .out_ready(out_ready_r[0]),
      .sum(sum0), .cout(cout_w[0]), .ovf(ovf_w[0]));

   digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_r[1]), .in_ready(in_ready_w[1]),
      .a(a_r[1]), .b(b_r[1]), .cin(cin_r[1]), .sub(sub_r[1]),
      .out_valid(out_valid_w[1]), .out_ready(out_ready_r[1]),
      .sum(sum1), .cout(cout_w[1]), .ovf(ovf_w[1]));

   digit_serial_adder #(.WIDTH(4), .DIGIT(4)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid_r[2]), .in_ready(in_ready_w[2]),
      .a(a_r[2][3:0]), .b(b_r[2][3:0]), .cin(cin_r[2]), .sub(sub_r[2]),
      .out_valid(out_valid_w[2]), .out_ready(out_ready_r[2]),
      .sum(sum2), .cout(cout_w[2]), .ovf(ovf_w[2]));

   typedef struct {
      int         inst;
      logic [7:0] a, b;
      logic       cin, sub;
      logic [7:0] exp_sum;
      logic       exp_cout, exp_ovf;
      int         exp_lat;
   } vec_t;

   function automatic logic [7:0] get_sum(input int i);
      case (i)
         0:       return sum0;
         1:       return sum1;
         default: return {4'h0, sum2};
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic void model(input int w, input int unsigned a, input int unsigned b,
                                 input bit c, input bit s, output int unsigned es,
                                 output bit ec, output bit eo);
      int unsigned mask, bb, full;
      bit sa, sb, ss;
      mask = (32'd1 << w) - 1;
      bb   = s ? (~b & mask) : (b & mask);
      full = (a & mask) + bb + (s ? 1 : c);
      es   = full & mask;
      ec   = ((full >> w) & 1) != 0;
      sa   = ((a >> (w - 1)) & 1) != 0;
      sb   = ((bb >> (w - 1)) & 1) != 0;
      ss   = ((es >> (w - 1)) & 1) != 0;
      eo   = (sa == sb) && (ss != sa);
   endfunction

   task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic s, output logic [7:0] rs,
                         output logic rc, output logic ro, output int lat);
      int n = 0;
      @(negedge clk);
      while (!in_ready_w[i] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
      a_r[i] = a; b_r[i] = b; cin_r[i] = c; sub_r[i] = s;
      in_valid_r[i] = 1'b1;
      @(posedge clk);
      #1 in_valid_r[i] = 1'b0;
      lat = 0;
      while (!out_valid_w[i] && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rs = get_sum(i);
      rc = cout_w[i];
      ro = ovf_w[i];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[$];
      logic [7:0]  rs;
      logic        rc, ro;
      int          lat;
      int unsigned es;
      bit          ec, eo;
      bit          seen;

      for (int i = 0; i < 3; i++) begin
         in_valid_r[i] = 1'b0; out_ready_r[i] = 1'b1;
         cin_r[i] = 1'b0; sub_r[i] = 1'b0; a_r[i] = 8'h00; b_r[i] = 8'h00;
      end

      vecs.push_back('{0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 8});
      vecs.push_back('{0, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8});
      vecs.push_back('{0, 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 8});
      vecs.push_back('{0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8});
      vecs.push_back('{1, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 2});
      vecs.push_back('{1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 2});
      vecs.push_back('{1, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 2});
      vecs.push_back('{2, 8'h07, 8'h01, 1'b0, 1'b0, 8'h08, 1'b0, 1'b1, 1});
      vecs.push_back('{2, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1});
      vecs.push_back('{2, 8'h03, 8'h05, 1'b0, 1'b1, 8'h0E, 1'b0, 1'b0, 1});
      vecs.push_back('{2, 8'h08, 8'h01, 1'b1, 1'b1, 8'h07, 1'b1, 1'b1, 1});

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("in_ready_during_rst", 32'(in_ready_w[0]), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("reset_in_ready", 32'(in_ready_w[i]), 32'd1);
         chk("reset_out_valid", 32'(out_valid_w[i]), 32'd0);
         chk("reset_sum", 32'(get_sum(i)), 32'd0);
      end

      // Directed table
      foreach (vecs[k]) begin
         run_op(vecs[k].inst, vecs[k].a, vecs[k].b, vecs[k].cin, vecs[k].sub, rs, rc, ro, lat);
         chk("vec_sum", 32'(rs), 32'(vecs[k].exp_sum));
         chk("vec_cout", 32'(rc), 32'(vecs[k].exp_cout));
         chk("vec_ovf", 32'(ro), 32'(vecs[k].exp_ovf));
         chk("vec_latency", 32'(lat), 32'(vecs[k].exp_lat));
      end

      // Backpressure in DONE with a pending in_valid
      out_ready_r[0] = 1'b0;
      run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, rs, rc, ro, lat);
      chk("bp_first_sum", 32'(rs), 32'h46);
      a_r[0] = 8'h01; b_r[0] = 8'h02; cin_r[0] = 1'b0; sub_r[0] = 1'b0;
      in_valid_r[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid_w[0]), 32'd1);
         chk("bp_sum_stable", 32'(sum0), 32'h46);
         chk("bp_in_ready", 32'(in_ready_w[0]), 32'd0);
      end
      out_ready_r[0] = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", 32'(in_ready_w[0]), 32'd1);
      chk("bp_release_out_valid", 32'(out_valid_w[0]), 32'd0);
      chk("bp_idle_sum_hold", 32'(sum0), 32'h46);
      @(posedge clk);
      #1 in_valid_r[0] = 1'b0;
      lat = 0;
      while (!out_valid_w[0] && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("bp_queued_latency", 32'(lat), 32'd8);
      chk("bp_queued_sum", 32'(sum0), 32'h03);

      // Reset in the middle of RUN
      @(negedge clk);
      a_r[0] = 8'hFF; b_r[0] = 8'hFF; cin_r[0] = 1'b1; sub_r[0] = 1'b0;
      in_valid_r[0] = 1'b1;
      @(posedge clk);
      #1 in_valid_r[0] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (out_valid_w[0]) seen = 1'b1;
      end
      chk("rst_no_out_valid", 32'(seen), 32'd0);
      chk("rst_sum", 32'(sum0), 32'd0);
      chk("rst_cout", 32'(cout_w[0]), 32'd0);
      chk("rst_ovf", 32'(ovf_w[0]), 32'd0);
      run_op(0, 8'h01, 8'h01, 1'b0, 1'b0, rs, rc, ro, lat);
      chk("post_rst_sum", 32'(rs), 32'h02);
      chk("post_rst_latency", 32'(lat), 32'd8);

      // Random operations against the arithmetic model
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 25; k++) begin
            logic [7:0] ra, rb;
            logic       rcin, rsub;
            int         w;
            w    = (i == 2) ? 4 : 8;
            ra   = 8'($urandom_range(0, (1 << w) - 1));
            rb   = 8'($urandom_range(0, (1 << w) - 1));
            rcin = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            model(w, 32'(ra), 32'(rb), rcin, rsub, es, ec, eo);
            run_op(i, ra, rb, rcin, rsub, rs, rc, ro, lat);
            chk("rand_sum", 32'(rs), es);
            chk("rand_cout", 32'(rc), 32'(ec));
            chk("rand_ovf", 32'(ro), 32'(eo));
            chk("rand_latency", 32'(lat), (i == 0) ? 32'd8 : ((i == 1) ? 32'd2 : 32'd1));
         end
      end

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
